// File: rtl/io_arb_pkg.sv
// Shared types and helpers for the two-client DMem read arbiter.
// Holds the FSM state encoding, the client count and the burst-length clamp.
package io_arb_pkg;

  localparam int NUM_CLIENTS = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADDR = 2'b01,
    ST_DATA = 2'b10
  } arb_state_e;

  // A zero length still moves one beat; anything at or above the cap is trimmed to the cap.
  function automatic logic [31:0] eff_beats(input logic [31:0] len, input logic [31:0] max_len);
    if (len == 32'd0)
      return 32'd1;
    else if (len < max_len)
      return len;
    else
      return max_len;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: with both requesting, the client not granted last wins.
// last is one-hot for the previous owner; the output gnt is one-hot or zero.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic [1:0] last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (req == 2'b11)
      gnt = last[0] ? 2'b10 : 2'b01;
    else
      gnt = req;
  end

endmodule

// File: rtl/io_read_arbiter.sv
// Arbitrates two read clients onto a single DMem IO controller port, one burst at a time.
// The winner's address and response channels are routed combinationally while it owns the port.
//
// state | meaning
// IDLE  | no owner; a winner is registered when any client asks
// ADDR  | winner's address request is presented downstream until it fires
// DATA  | responses routed to the winner until the clamped beat count is reached
module io_read_arbiter
  import io_arb_pkg::*;
#(
  parameter int AWIDTH        = 32,
  parameter int DWIDTH        = 32,
  parameter int MAX_BURST_LEN = 8
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic [AWIDTH-1:0] c0_req_read_addr,
  input  logic              c0_req_read_addr_valid,
  output logic              c0_req_read_addr_ready,
  input  logic [31:0]       c0_req_read_len,
  output logic [DWIDTH-1:0] c0_resp_read_data,
  output logic              c0_resp_read_data_valid,
  input  logic              c0_resp_read_data_ready,

  input  logic [AWIDTH-1:0] c1_req_read_addr,
  input  logic              c1_req_read_addr_valid,
  output logic              c1_req_read_addr_ready,
  input  logic [31:0]       c1_req_read_len,
  output logic [DWIDTH-1:0] c1_resp_read_data,
  output logic              c1_resp_read_data_valid,
  input  logic              c1_resp_read_data_ready,

  output logic [AWIDTH-1:0] m_req_read_addr,
  output logic [31:0]       m_req_read_len,
  output logic              m_req_read_addr_valid,
  input  logic              m_req_read_addr_ready,
  input  logic [DWIDTH-1:0] m_resp_read_data,
  input  logic              m_resp_read_data_valid,
  output logic              m_resp_read_data_ready,

  output logic [1:0]        grant,
  output logic              busy
);

  localparam logic [31:0] MAX_BEATS = 32'(MAX_BURST_LEN);

  arb_state_e             state_q, state_d;
  logic [1:0]             win_q, win_d;
  logic [1:0]             last_q, last_d;
  logic [31:0]            beats_q, beats_d;
  logic [31:0]            cnt_q, cnt_d;
  logic [NUM_CLIENTS-1:0] req_vec;
  logic [1:0]             rr_gnt;
  logic                   sel;
  logic                   sel_addr_valid;
  logic                   sel_resp_ready;
  logic [31:0]            sel_len;

  assign req_vec = {c1_req_read_addr_valid, c0_req_read_addr_valid};
  assign sel     = win_q[1];

  rr_arb2 u_rr (
    .req  (req_vec),
    .last (last_q),
    .gnt  (rr_gnt)
  );

  // last_q resets to "c1 served last" so c0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      win_q   <= 2'b00;
      last_q  <= 2'b10;
      beats_q <= 32'd0;
      cnt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      last_q  <= last_d;
      beats_q <= beats_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    last_d  = last_q;
    beats_d = beats_q;
    cnt_d   = cnt_q;

    m_req_read_addr         = '0;
    m_req_read_len          = '0;
    m_req_read_addr_valid   = 1'b0;
    m_resp_read_data_ready  = 1'b0;
    c0_req_read_addr_ready  = 1'b0;
    c1_req_read_addr_ready  = 1'b0;
    c0_resp_read_data       = '0;
    c1_resp_read_data       = '0;
    c0_resp_read_data_valid = 1'b0;
    c1_resp_read_data_valid = 1'b0;

    sel_addr_valid = sel ? c1_req_read_addr_valid  : c0_req_read_addr_valid;
    sel_resp_ready = sel ? c1_resp_read_data_ready : c0_resp_read_data_ready;
    sel_len        = sel ? c1_req_read_len         : c0_req_read_len;

    unique case (state_q)
      ST_IDLE: begin
        if (|req_vec) begin
          win_d   = rr_gnt;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        m_req_read_addr       = sel ? c1_req_read_addr : c0_req_read_addr;
        m_req_read_len        = sel_len;
        m_req_read_addr_valid = sel_addr_valid;
        if (sel) c1_req_read_addr_ready = m_req_read_addr_ready;
        else     c0_req_read_addr_ready = m_req_read_addr_ready;
        if (sel_addr_valid && m_req_read_addr_ready) begin
          beats_d = eff_beats(sel_len, MAX_BEATS);
          cnt_d   = 32'd0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        m_resp_read_data_ready = sel_resp_ready;
        if (sel) begin
          c1_resp_read_data       = m_resp_read_data;
          c1_resp_read_data_valid = m_resp_read_data_valid;
        end else begin
          c0_resp_read_data       = m_resp_read_data;
          c0_resp_read_data_valid = m_resp_read_data_valid;
        end
        if (m_resp_read_data_valid && sel_resp_ready) begin
          cnt_d = cnt_q + 32'd1;
          if (cnt_q == beats_q - 32'd1) begin
            last_d  = win_q;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign grant = (state_q == ST_IDLE) ? 2'b00 : win_q;
  assign busy  = (state_q != ST_IDLE);

endmodule
